// File: rtl/bsod_mode_ctrl.sv
// bsod_mode_ctrl: sequences the HDMI switch between pass-through and the BSOD generator.
// The generator is enabled before switch-over and disabled only after switch-back.
module bsod_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int SETTLE_CYCLES       = 50000,
    parameter int BSOD_TIMEOUT_CYCLES = 0
) (
    input  logic       CLOCK_50_B5B,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       cfg_done,
    input  logic       trigger_n,
    input  logic       force_bsod,
    output logic       vg_enable,
    output logic       hdmi_sw,
    output logic       bsod_active,
    output logic [2:0] state_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int CMAX = SETTLE_CYCLES > BSOD_TIMEOUT_CYCLES ? SETTLE_CYCLES : BSOD_TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX) + 1;
    localparam bit TMO_EN = BSOD_TIMEOUT_CYCLES > 0;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_EN ? BSOD_TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {INIT = 3'd0, PASS = 3'd1, ARM = 3'd2, BSOD = 3'd3, DISARM = 3'd4} state_t;

    state_t state, state_nxt;
    logic lock_s1, lock_sync, trig_s1, trig_sync, force_s1, force_sync;
    logic trig_db, trig_db_q, press, toggle_req, toggle_nxt;
    logic online, timeout, target;
    logic [DW-1:0] db_cnt;
    logic [CW-1:0] cnt;

    always_comb begin
        online = lock_sync & cfg_done;
        timeout = TMO_EN && state == BSOD && cnt == TMO_LAST;
        toggle_nxt = (state inside {PASS, ARM, BSOD, DISARM}) && !timeout ? toggle_req ^ press : 1'b0;
        target = toggle_nxt | force_sync;
        state_nxt = INIT;
        case (state)
            INIT:    state_nxt = online ? PASS : INIT;
            PASS:    state_nxt = target ? ARM : PASS;
            ARM:     state_nxt = cnt == SETTLE_LAST ? BSOD : ARM;
            BSOD:    state_nxt = (!target || timeout) ? DISARM : BSOD;
            DISARM:  state_nxt = cnt == SETTLE_LAST ? PASS : DISARM;
            default: state_nxt = INIT;
        endcase
        // losing lock or configuration drops straight to INIT, no settle sequence
        if (!online)
            state_nxt = INIT;
    end

    always_ff @(posedge CLOCK_50_B5B) begin
        if (!reset_n) begin
            lock_s1     <= 1'b0;
            lock_sync   <= 1'b0;
            trig_s1     <= 1'b1;
            trig_sync   <= 1'b1;
            force_s1    <= 1'b0;
            force_sync  <= 1'b0;
            db_cnt      <= '0;
            trig_db     <= 1'b1;
            trig_db_q   <= 1'b1;
            press       <= 1'b0;
            toggle_req  <= 1'b0;
            state       <= INIT;
            cnt         <= '0;
            vg_enable   <= 1'b0;
            hdmi_sw     <= 1'b1;
            bsod_active <= 1'b0;
        end else begin
            lock_s1     <= pll_locked;
            lock_sync   <= lock_s1;
            trig_s1     <= trigger_n;
            trig_sync   <= trig_s1;
            force_s1    <= force_bsod;
            force_sync  <= force_s1;
            db_cnt      <= (trig_sync == trig_db || db_cnt == DB_LAST) ? '0 : db_cnt + 1'b1;
            trig_db     <= (trig_sync != trig_db && db_cnt == DB_LAST) ? trig_sync : trig_db;
            trig_db_q   <= trig_db;
            press       <= trig_db_q & ~trig_db;
            toggle_req  <= toggle_nxt;
            state       <= state_nxt;
            cnt         <= state_nxt != state ? '0 :
                           (state == ARM || state == DISARM || (TMO_EN && state == BSOD)) ? cnt + 1'b1 : cnt;
            vg_enable   <= state_nxt inside {ARM, BSOD, DISARM};
            hdmi_sw     <= state_nxt != BSOD;
            bsod_active <= state_nxt == BSOD;
        end
    end

    assign state_o = state;
endmodule
